// File: rtl/sdrc_req_arb_pkg.sv
// Shared SDRC arbiter encodings: request-ID width and FSM state codes.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif
`ifndef ARB_IDLE
`define ARB_IDLE 1'b0
`endif
`ifndef ARB_GRANT
`define ARB_GRANT 1'b1
`endif

package sdrc_req_arb_pkg;

    localparam int ARB_PW = 3;
    localparam int ARB_IDW = `SDR_REQ_ID_W;

    typedef enum logic {
        ARB_IDLE  = `ARB_IDLE,
        ARB_GRANT = `ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin search: first set request above last_i, wrapping to 0.
// Zero latency; no flow control of its own.
module sdrc_rr_pick #(
    parameter int NP = 4
) (
    input  logic [NP-1:0] req_i,
    input  logic [2:0]    last_i,
    output logic [2:0]    win_o,
    output logic          vld_o
);
    import sdrc_req_arb_pkg::*;

    logic [ARB_PW-1:0] win_hi, win_lo;
    logic              vld_hi, vld_lo;

    // Descending scan lets the lowest index in each half overwrite the others.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        vld_hi = 1'b0;
        vld_lo = 1'b0;
        for (int j = NP - 1; j >= 0; j--) begin
            if (req_i[j] && (3'(j) > last_i)) begin
                win_hi = 3'(j);
                vld_hi = 1'b1;
            end
            if (req_i[j] && (3'(j) <= last_i)) begin
                win_lo = 3'(j);
                vld_lo = 1'b1;
            end
        end
    end

    assign win_o = vld_hi ? win_hi : win_lo;
    assign vld_o = vld_hi | vld_lo;

endmodule

// File: rtl/sdrc_req_arb.sv
// SDRC request arbiter: 1 cycle p_req->req, one acceptance per 2 cycles; grant held until req_ack or withdrawal.
// Define SDRC_ARB_PRIO_EN to give port 0 absolute priority over round-robin ports 1..NP-1.
module sdrc_req_arb #(
    parameter int NP     = 4,
    parameter int APP_AW = 30,
    parameter int APP_RW = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NP-1:0]                 p_req,
    input  logic [NP*`SDR_REQ_ID_W-1:0]   p_id,
    input  logic [NP*APP_AW-1:0]          p_addr,
    input  logic [NP*APP_RW-1:0]          p_len,
    input  logic [NP-1:0]                 p_wr_n,
    input  logic [NP-1:0]                 p_wrap,
    output logic [NP-1:0]                 p_ack,
    output logic                          req,
    output logic [`SDR_REQ_ID_W-1:0]      req_id,
    output logic [APP_AW-1:0]             req_addr,
    output logic [APP_RW-1:0]             req_len,
    output logic                          req_wr_n,
    output logic                          req_wrap,
    input  logic                          req_ack,
    output logic [2:0]                    arb_port
);
    import sdrc_req_arb_pkg::*;

    localparam int IDW = `SDR_REQ_ID_W;

    arb_state_e        state_q, state_d;
    logic [ARB_PW-1:0] grant_q, grant_d;
    logic [ARB_PW-1:0] last_q, last_d;

    logic [NP-1:0]     pick_req;
    logic [ARB_PW-1:0] pick_win, sel_win;
    logic              pick_vld, sel_vld;
    logic              cur_req;
    logic [NP-1:0]     ack_vec;

`ifdef SDRC_ARB_PRIO_EN
    // Port 0 bypasses the rotation; the picker only rotates among the rest.
    assign pick_req = {p_req[NP-1:1], 1'b0};
    assign sel_vld  = p_req[0] | pick_vld;
    assign sel_win  = p_req[0] ? '0 : pick_win;
`else
    assign pick_req = p_req;
    assign sel_vld  = pick_vld;
    assign sel_win  = pick_win;
`endif

    sdrc_rr_pick #(.NP(NP)) u_rr_pick (
        .req_i  (pick_req),
        .last_i (last_q),
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    always_comb begin
        cur_req  = 1'b0;
        ack_vec  = '0;
        req_id   = '0;
        req_addr = '0;
        req_len  = '0;
        req_wr_n = 1'b1;
        req_wrap = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (grant_q == 3'(i)) begin
                cur_req    = p_req[i];
                ack_vec[i] = 1'b1;
                req_id     = p_id[i*IDW +: IDW];
                req_addr   = p_addr[i*APP_AW +: APP_AW];
                req_len    = p_len[i*APP_RW +: APP_RW];
                req_wr_n   = p_wr_n[i];
                req_wrap   = p_wrap[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        req     = 1'b0;
        p_ack   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (sel_vld) begin
                    grant_d = sel_win;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                req = cur_req;
                if (req_ack) begin
                    p_ack   = ack_vec;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end else if (!cur_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= 3'(NP - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign arb_port = grant_q;

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Directed bench for sdrc_req_arb: per-cycle vector table plus hold and async-reset sequences.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

module tb_sdrc_req_arb;
    localparam int NP  = 4;
    localparam int AW  = 30;
    localparam int RW  = 9;
    localparam int IDW = `SDR_REQ_ID_W;
    localparam int NV  = 30;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     p_req, p_wr_n, p_wrap, p_ack;
    logic [NP*IDW-1:0] p_id;
    logic [NP*AW-1:0]  p_addr;
    logic [NP*RW-1:0]  p_len;
    logic              req, req_wr_n, req_wrap, req_ack;
    logic [IDW-1:0]    req_id;
    logic [AW-1:0]     req_addr;
    logic [RW-1:0]     req_len;
    logic [2:0]        arb_port;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdrc_req_arb #(.NP(NP), .APP_AW(AW), .APP_RW(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_req(p_req), .p_id(p_id), .p_addr(p_addr), .p_len(p_len),
        .p_wr_n(p_wr_n), .p_wrap(p_wrap), .p_ack(p_ack),
        .req(req), .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .req_wr_n(req_wr_n), .req_wrap(req_wrap), .req_ack(req_ack),
        .arb_port(arb_port)
    );

    typedef struct {
        logic          rst;
        logic [NP-1:0] preq;
        logic          ack;
        logic          exp_req;
        logic [NP-1:0] exp_ack;
        logic [2:0]    exp_port;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h0001_0000 + i * 32'h100);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  served;

        reset_n = 1'b0;
        p_req   = '0;
        req_ack = 1'b0;
        p_wr_n  = 4'b0101;
        p_wrap  = 4'b0011;
        for (int i = 0; i < NP; i++) begin
            p_id[i*IDW +: IDW]  = IDW'(i + 1);
            p_addr[i*AW +: AW]  = addr_of(i);
            p_len[i*RW +: RW]   = RW'(i * 8 + 1);
        end

        // Single requester, then all four held, then port 3 withdrawing.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[2]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 3'd1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd1};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 3'd2};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd2};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 3'd3};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd3};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[15] = '{1'b1, 4'b0111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[16] = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[17] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[18] = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b0000, 3'd0};
`ifdef SDRC_ARB_PRIO_EN
        tbl[19] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[20] = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[21] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0001, 3'd0};
`else
        tbl[19] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0010, 3'd1};
        tbl[20] = '{1'b0, 4'b0111, 1'b1, 1'b0, 4'b0000, 3'd1};
        tbl[21] = '{1'b0, 4'b0111, 1'b1, 1'b1, 4'b0100, 3'd2};
`endif
        tbl[22] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0};
        tbl[23] = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 3'd0};
        tbl[24] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 3'd0};
        tbl[25] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 3'd0};
        tbl[26] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 3'd3};
        tbl[27] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd3};
        tbl[28] = '{1'b0, 4'b0011, 1'b1, 1'b0, 4'b0000, 3'd3};
`ifdef SDRC_ARB_PRIO_EN
        tbl[29] = '{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 3'd0};
`else
        tbl[29] = '{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0010, 3'd1};
`endif

        tick();
        for (int v = 0; v < NV; v++) begin
            reset_n = ~tbl[v].rst;
            p_req   = tbl[v].preq;
            req_ack = tbl[v].ack;
            @(negedge clk);
            chk($sformatf("row%0d_req", v), 32'(req), 32'(tbl[v].exp_req));
            chk($sformatf("row%0d_p_ack", v), 32'(p_ack), 32'(tbl[v].exp_ack));
            chk($sformatf("row%0d_arb_port", v), 32'(arb_port), 32'(tbl[v].exp_port));
            if (tbl[v].exp_req) begin
                n = int'(tbl[v].exp_port);
                chk($sformatf("row%0d_req_addr", v), 32'(req_addr), 32'(addr_of(n)));
                chk($sformatf("row%0d_req_id", v), 32'(req_id), 32'(n + 1));
                chk($sformatf("row%0d_req_len", v), 32'(req_len), 32'(n * 8 + 1));
                chk($sformatf("row%0d_req_wr_n", v), 32'(req_wr_n), 32'(p_wr_n[n]));
                chk($sformatf("row%0d_req_wrap", v), 32'(req_wrap), 32'(p_wrap[n]));
            end
            tick();
        end

        // Grant to port 2 stalled by req_ack=0 while port 1 also requests.
        reset_n = 1'b0; p_req = '0; req_ack = 1'b0;
        tick();
        reset_n = 1'b1; p_req = 4'b0100;
        tick();
        p_req = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_req", k), 32'(req), 32'd1);
            chk($sformatf("hold%0d_addr", k), 32'(req_addr), 32'h0001_0200);
            chk($sformatf("hold%0d_port", k), 32'(arb_port), 32'd2);
            chk($sformatf("hold%0d_p_ack", k), 32'(p_ack), 32'd0);
            tick();
        end
        req_ack = 1'b1;
        @(negedge clk);
        chk("hold_release_p_ack", 32'(p_ack), 32'b0100);
        tick();
        p_req  = 4'b0010;
        served = 1'b0;
        n      = 0;
        while (!served && n < 8) begin
            @(negedge clk);
            if (p_ack[1]) begin
                served = 1'b1;
                chk("p1_addr", 32'(req_addr), 32'(addr_of(1)));
            end else begin
                n++;
            end
            tick();
        end
        chk("p1_served", 32'(served), 32'd1);
        chk("p1_wait_cycles", 32'(n), 32'd1);
        p_req = '0; req_ack = 1'b0;

        // Asynchronous reset in the middle of a grant.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; p_req = 4'b0100;
        tick();
        @(negedge clk);
        chk("arst_pre_req", 32'(req), 32'd1);
        #2;
        req_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("arst_req_drop", 32'(req), 32'd0);
        chk("arst_no_ack", 32'(p_ack), 32'd0);
        chk("arst_port", 32'(arb_port), 32'd0);
        tick();
        reset_n = 1'b1; p_req = 4'b0110;
        tick();
        @(negedge clk);
        chk("arst_first_p_ack", 32'(p_ack), 32'b0010);
        chk("arst_first_port", 32'(arb_port), 32'd1);
        tick();
        p_req = '0; req_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
